// File: rtl/ysyx_25040111_lsu.sv
// Load/store unit: takes one EXU request at a time, issues an aligned memory
// access when needed, and retires the result with GPR/CSR writeback.
module ysyx_25040111_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abt_valid,
   input  logic        abt_men,
   input  logic        abt_write,
   input  logic [31:0] abt_addr,
   input  logic [31:0] abt_wdata,
   input  logic [1:0]  abt_mask,
   input  logic        abt_rsign,
   input  logic [4:0]  abt_ard,
   input  logic [31:0] abt_rd,
   input  logic        abt_gen,
   input  logic [11:0] abt_acsr,
   input  logic [31:0] abt_csr,
   input  logic        abt_sen,
   input  logic [31:0] abt_pc,
   output logic        abt_ready,
   output logic        abt_finish,
   output logic [4:0]  abt_frd,
   output logic        mem_req_valid,
   output logic        mem_req_write,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        gpr_wen,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wdata,
   output logic        csr_wen,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic [31:0] commit_pc,
   output logic        lsu_err,
   output logic [3:0]  lsu_errtp
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WB
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          berr_q, berr_d;

   logic          men_q, write_q, rsign_q, gen_q, sen_q, mis_q;
   logic [31:0]   addr_q, wdata_q, rd_q, csr_q, pc_q;
   logic [1:0]    mask_q;
   logic [4:0]    ard_q;
   logic [11:0]   acsr_q;

   logic          accept;
   logic          mis_in;
   logic          is_load;
   logic          err;
   logic [31:0]   ld_sh;
   logic [31:0]   ld_data;
   logic [31:0]   st_data;
   logic [3:0]    st_strb;

   assign abt_ready = rst_n & (state_q == S_IDLE);
   assign accept    = abt_valid & abt_ready;
   assign mis_in    = abt_men & (((abt_mask == 2'b10) & abt_addr[0]) |
                                 ((abt_mask == 2'b11) & (|abt_addr[1:0])));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         berr_q  <= berr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         men_q   <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rsign_q <= 1'b0;
         ard_q   <= '0;
         rd_q    <= '0;
         gen_q   <= 1'b0;
         acsr_q  <= '0;
         csr_q   <= '0;
         sen_q   <= 1'b0;
         pc_q    <= '0;
         mis_q   <= 1'b0;
      end else if (accept) begin
         men_q   <= abt_men;
         write_q <= abt_write;
         addr_q  <= abt_addr;
         wdata_q <= abt_wdata;
         mask_q  <= abt_mask;
         rsign_q <= abt_rsign;
         ard_q   <= abt_ard;
         rd_q    <= abt_rd;
         gen_q   <= abt_gen;
         acsr_q  <= abt_acsr;
         csr_q   <= abt_csr;
         sen_q   <= abt_sen;
         pc_q    <= abt_pc;
         mis_q   <= mis_in;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      berr_d  = berr_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (abt_men & ~mis_in) ? S_REQ : S_WB;
               cnt_d   = '0;
               berr_d  = 1'b0;
            end
         end
         S_REQ: begin
            cnt_d = '0;
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A response on the last counted cycle still wins over the timeout.
            if (mem_resp_valid) begin
               rdata_d = mem_resp_data;
               berr_d  = mem_resp_err;
               state_d = S_WB;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               berr_d  = 1'b1;
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      st_strb = 4'b0000;
      st_data = '0;
      ld_sh   = rdata_q >> {addr_q[1:0], 3'b000};
      ld_data = rdata_q;
      unique case (mask_q)
         2'b01: begin
            st_strb = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
            ld_data = {{24{rsign_q & ld_sh[7]}}, ld_sh[7:0]};
         end
         2'b10: begin
            st_strb = 4'b0011 << addr_q[1:0];
            st_data = {2{wdata_q[15:0]}};
            ld_data = {{16{rsign_q & ld_sh[15]}}, ld_sh[15:0]};
         end
         default: begin
            st_strb = 4'b1111 << addr_q[1:0];
            st_data = wdata_q;
         end
      endcase
   end

   assign is_load = men_q & ~write_q;
   assign err     = mis_q | berr_q;

   always_comb begin
      abt_finish    = 1'b0;
      abt_frd       = '0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      mem_req_wstrb = '0;
      gpr_wen       = 1'b0;
      gpr_waddr     = '0;
      gpr_wdata     = '0;
      csr_wen       = 1'b0;
      csr_waddr     = '0;
      csr_wdata     = '0;
      commit_pc     = '0;
      lsu_err       = 1'b0;
      lsu_errtp     = '0;
      if (state_q == S_REQ) begin
         mem_req_valid = 1'b1;
         mem_req_write = write_q;
         mem_req_addr  = {addr_q[31:2], 2'b00};
         mem_req_wdata = write_q ? st_data : '0;
         mem_req_wstrb = write_q ? st_strb : 4'b0000;
      end
      if (state_q == S_WB) begin
         abt_finish = 1'b1;
         abt_frd    = ard_q;
         commit_pc  = pc_q;
         gpr_wen    = (gen_q | (is_load & ~err)) & ~err & (|ard_q);
         gpr_waddr  = ard_q;
         gpr_wdata  = is_load ? ld_data : rd_q;
         csr_wen    = sen_q;
         csr_waddr  = acsr_q;
         csr_wdata  = csr_q;
         lsu_err    = err;
         // errtp: 4/6 misaligned load/store, 5/7 bus error or timeout.
         if (mis_q)       lsu_errtp = {2'b01, write_q, 1'b0};
         else if (berr_q) lsu_errtp = {2'b01, write_q, 1'b1};
      end
   end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed + randomized bench for ysyx_25040111_lsu; expected results come from
// an arithmetic transaction model, checked with immediate assertions.
module tb_ysyx_25040111_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        abt_valid, abt_men, abt_write, abt_rsign, abt_gen, abt_sen;
   logic [31:0] abt_addr, abt_wdata, abt_rd, abt_csr, abt_pc;
   logic [1:0]  abt_mask;
   logic [4:0]  abt_ard;
   logic [11:0] abt_acsr;
   logic        abt_ready, abt_finish;
   logic [4:0]  abt_frd;
   logic        mem_req_valid, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_req_ready, mem_resp_valid, mem_resp_err;
   logic [31:0] mem_resp_data;
   logic        gpr_wen, csr_wen, lsu_err;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata, csr_wdata, commit_pc;
   logic [11:0] csr_waddr;
   logic [3:0]  lsu_errtp;

   int checks = 0;
   int errors = 0;

   ysyx_25040111_lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .abt_valid(abt_valid), .abt_men(abt_men), .abt_write(abt_write),
      .abt_addr(abt_addr), .abt_wdata(abt_wdata), .abt_mask(abt_mask),
      .abt_rsign(abt_rsign), .abt_ard(abt_ard), .abt_rd(abt_rd),
      .abt_gen(abt_gen), .abt_acsr(abt_acsr), .abt_csr(abt_csr),
      .abt_sen(abt_sen), .abt_pc(abt_pc),
      .abt_ready(abt_ready), .abt_finish(abt_finish), .abt_frd(abt_frd),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .commit_pc(commit_pc), .lsu_err(lsu_err), .lsu_errtp(lsu_errtp)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic scramble_abt();
      abt_men   = 1'($urandom);  abt_write = 1'($urandom);
      abt_addr  = $urandom;      abt_wdata = $urandom;
      abt_mask  = 2'($urandom);  abt_rsign = 1'($urandom);
      abt_ard   = 5'($urandom);  abt_rd    = $urandom;
      abt_gen   = 1'($urandom);  abt_acsr  = 12'($urandom);
      abt_csr   = $urandom;      abt_sen   = 1'($urandom);
      abt_pc    = $urandom;
   endtask

   // One complete transaction; rsp_dly = WAIT cycles before the response
   // (>= TMO means no response at all).
   task automatic run_txn(
      input bit men, input bit write, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [1:0] mask, input bit rsign,
      input logic [4:0] ard, input logic [31:0] rd, input bit gen,
      input logic [11:0] acsr, input logic [31:0] csr, input bit sen,
      input logic [31:0] pc, input int rdy_dly, input int rsp_dly,
      input logic [31:0] rsp_data, input bit rsp_err);
      int          off, size, nw;
      bit          mis, ismem, timeout, berr, err, isload, e_gwen;
      logic [31:0] e_strb, e_wd, e_ld, v;
      logic [3:0]  e_tp;

      off     = int'(addr % 4);
      size    = (mask == 2'd1) ? 1 : (mask == 2'd2) ? 2 : 4;
      mis     = men && ((mask == 2'd2 && addr % 2 != 0) || (mask == 2'd3 && off != 0));
      ismem   = men && !mis;
      e_strb  = write ? ((((32'd1 << size) - 1) << off) & 32'd15) : 32'd0;
      e_wd    = !write ? 32'd0 :
                (size == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                (size == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
      v       = rsp_data >> (8 * off);
      if (size == 1) begin
         e_ld = v & 32'hFF;
         if (rsign && e_ld >= 32'd128) e_ld = e_ld - 32'd256;
      end else if (size == 2) begin
         e_ld = v & 32'hFFFF;
         if (rsign && e_ld >= 32'd32768) e_ld = e_ld - 32'd65536;
      end else begin
         e_ld = rsp_data;
      end
      timeout = rsp_dly >= TMO;
      berr    = ismem && (timeout || rsp_err);
      err     = mis || berr;
      isload  = men && !write;
      e_gwen  = (gen || (isload && !err)) && !err && ard != 5'd0;
      e_tp    = mis ? (write ? 4'd6 : 4'd4) : (write ? 4'd7 : 4'd5);

      @(negedge clk);
      chk("idle_ready", abt_ready, 1);
      abt_valid = 1'b1; abt_men = men; abt_write = write; abt_addr = addr;
      abt_wdata = wdata; abt_mask = mask; abt_rsign = rsign; abt_ard = ard;
      abt_rd = rd; abt_gen = gen; abt_acsr = acsr; abt_csr = csr;
      abt_sen = sen; abt_pc = pc;
      @(negedge clk);
      abt_valid = 1'b0;
      scramble_abt();
      chk("busy_ready", abt_ready, 0);

      if (ismem) begin
         for (int k = 0; k <= rdy_dly; k++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_write", mem_req_write, 32'(write));
            chk("req_addr", mem_req_addr, addr & 32'hFFFFFFFC);
            chk("req_wdata", mem_req_wdata, e_wd);
            chk("req_wstrb", mem_req_wstrb, e_strb);
            chk("req_finish", abt_finish, 0);
            chk("req_gwen", gpr_wen, 0);
            chk("req_err", lsu_err, 0);
            mem_req_ready  = (k == rdy_dly);
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            mem_resp_err   = 1'b1;
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         nw = timeout ? TMO : rsp_dly + 1;
         for (int w = 0; w < nw; w++) begin
            chk("wait_valid", mem_req_valid, 0);
            chk("wait_finish", abt_finish, 0);
            chk("wait_csr", csr_wen, 0);
            mem_resp_valid = (w == rsp_dly);
            mem_resp_data  = (w == rsp_dly) ? rsp_data : $urandom;
            mem_resp_err   = rsp_err;
            @(negedge clk);
         end
         mem_resp_valid = 1'b0;
         mem_resp_err   = 1'b0;
      end else begin
         chk("nomem_valid", mem_req_valid, 0);
      end

      chk("wb_finish", abt_finish, 1);
      chk("wb_frd", abt_frd, 32'(ard));
      chk("wb_pc", commit_pc, pc);
      chk("wb_gwen", gpr_wen, 32'(e_gwen));
      if (e_gwen) begin
         chk("wb_gaddr", gpr_waddr, 32'(ard));
         chk("wb_gdata", gpr_wdata, isload ? e_ld : rd);
      end
      chk("wb_cwen", csr_wen, 32'(sen));
      if (sen) begin
         chk("wb_caddr", csr_waddr, 32'(acsr));
         chk("wb_cdata", csr_wdata, csr);
      end
      chk("wb_err", lsu_err, 32'(err));
      if (err) chk("wb_errtp", lsu_errtp, 32'(e_tp));
      @(negedge clk);
      chk("post_finish", abt_finish, 0);
      chk("post_gwen", gpr_wen, 0);
      chk("post_ready", abt_ready, 1);
   endtask

   // Reset in REQ (in_wait=0) or WAIT (in_wait=1) must abort without retiring.
   task automatic reset_mid(input bit in_wait);
      @(negedge clk);
      abt_valid = 1'b1; abt_men = 1'b1; abt_write = 1'b0; abt_mask = 2'd3;
      abt_addr = 32'h80000010; abt_gen = 1'b1; abt_ard = 5'd9; abt_sen = 1'b1;
      @(negedge clk);
      abt_valid = 1'b0;
      chk("rst_pre_req", mem_req_valid, 1);
      if (in_wait) begin
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         chk("rst_pre_wait", mem_req_valid, 0);
      end
      rst_n = 1'b0;
      #1;
      chk("rst_ready", abt_ready, 0);
      chk("rst_valid", mem_req_valid, 0);
      chk("rst_finish", abt_finish, 0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEADBEEF;
      @(negedge clk);
      chk("rst_gwen", gpr_wen, 0);
      chk("rst_cwen", csr_wen, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rel_ready", abt_ready, 1);
         chk("rel_finish", abt_finish, 0);
         chk("rel_gwen", gpr_wen, 0);
         chk("rel_valid", mem_req_valid, 0);
      end
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      abt_valid = 1'b0;
      scramble_abt();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_data = '0;   mem_resp_err = 1'b0;

      repeat (2) @(negedge clk);
      chk("reset_ready", abt_ready, 0);
      chk("reset_valid", mem_req_valid, 0);
      chk("reset_finish", abt_finish, 0);
      chk("reset_gwen", gpr_wen, 0);
      chk("reset_err", lsu_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_ready", abt_ready, 1);

      // non-memory writeback
      run_txn(0, 0, 32'h0, 32'h0, 2'd3, 0, 5'd5, 32'h1234, 1,
              12'h300, 32'h55, 0, 32'h80000100, 0, 0, 32'h0, 0);
      // signed / unsigned byte load from top lane
      run_txn(1, 0, 32'h80000003, 32'h0, 2'd1, 1, 5'd7, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h80000104, 0, 0, 32'h80FF0000, 0);
      run_txn(1, 0, 32'h80000003, 32'h0, 2'd1, 0, 5'd7, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h80000108, 0, 0, 32'h80FF0000, 0);
      // half store to upper lane
      run_txn(1, 1, 32'h80000002, 32'hABCD, 2'd2, 0, 5'd3, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h8000010C, 0, 1, 32'h0, 0);
      // misaligned word load
      run_txn(1, 0, 32'h80000001, 32'h0, 2'd3, 0, 5'd4, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h80000110, 0, 0, 32'h0, 0);
      // ready held low 10 cycles then bus error on load, CSR write still done
      run_txn(1, 0, 32'h80000020, 32'h0, 2'd3, 0, 5'd6, 32'h0, 0,
              12'h341, 32'hCAFE0001, 1, 32'h80000114, 10, 0, 32'h11223344, 1);
      // store timeout after TMO wait cycles
      run_txn(1, 1, 32'h80000024, 32'h9ABC, 2'd3, 0, 5'd2, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h80000118, 0, 99, 32'h0, 0);
      // response on the final counted wait cycle beats the timeout
      run_txn(1, 0, 32'h80000028, 32'h0, 2'd2, 1, 5'd8, 32'h0, 0,
              12'h0, 32'h0, 0, 32'h8000011C, 1, TMO - 1, 32'h0000F00D, 0);

      reset_mid(1);
      reset_mid(0);

      for (int n = 0; n < 40; n++) begin
         run_txn(1'($urandom), 1'($urandom), 32'h80000000 | ($urandom & 32'hFFF),
                 $urandom, 2'($urandom_range(1, 3)), 1'($urandom),
                 5'($urandom), $urandom, 1'($urandom), 12'($urandom), $urandom,
                 1'($urandom), $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 5), $urandom, ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_25040111_lsu.md
YSYX_25040111_LSU -- requirements
Module: ysyx_25040111_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of cycles to wait for a memory response before an access fault.
REQ-002 SHALL have clock  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have the following EXU request channel inputs:
- abt_valid  input  1
- abt_men  input  1  memory access
- abt_write  input  1  1=store
- abt_addr  input  32
- abt_wdata  input  32
- abt_mask  input  2  01=byte, 10=half, 11=word
- abt_rsign  input  1  sign-extend load
REQ-005 SHALL have the following EXU writeback inputs:
- abt_ard  input  5
- abt_rd  input  32
- abt_gen  input  1
- abt_acsr  input  12
- abt_csr  input  32
- abt_sen  input  1
- abt_pc  input  32
REQ-006 SHALL have abt_ready  output  1  request accepted when abt_valid & abt_ready.
REQ-007 SHALL have abt_finish  output  1 and abt_frd  output  5, a retire pulse carrying the destination register.
REQ-008 SHALL have the following memory request outputs:
- mem_req_valid  output  1
- mem_req_write  output  1
- mem_req_addr  output  32  word-aligned
- mem_req_wdata  output  32  lane-aligned
- mem_req_wstrb  output  4
REQ-009 SHALL have mem_req_ready  input  1, mem_resp_valid  input  1, mem_resp_data  input  32, and mem_resp_err  input  1.
REQ-010 SHALL have the following writeback outputs:
- gpr_wen  output  1
- gpr_waddr  output  5
- gpr_wdata  output  32
- csr_wen  output  1
- csr_waddr  output  12
- csr_wdata  output  32
REQ-011 SHALL have commit_pc  output  32, lsu_err  output  1, and lsu_errtp  output  4.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT and WB.
REQ-013 SHALL drive abt_ready=1 only in IDLE while reset is deasserted.
REQ-014 On accept, SHALL latch all abt_* inputs and then move:
- to REQ if abt_men and aligned;
- otherwise to WB.
REQ-015 SHALL treat an access as misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-016 A misaligned access SHALL be neither issued nor written to a GPR, and SHALL raise lsu_err with errtp 4 (load) or 6 (store) in WB.
REQ-017 In REQ, SHALL hold mem_req_valid=1 and all mem_req_* stable until mem_req_ready=1, then move to WAIT on the next edge.
REQ-018 mem_req_addr SHALL equal {addr[31:2],2'b00}.
REQ-019 Store wstrb SHALL be 0001, 0011 or 1111 shifted left by addr[1:0].
REQ-020 Store wdata SHALL be the low byte or half of abt_wdata replicated to the addressed lane.
REQ-021 Load wstrb SHALL be 0000.
REQ-022 In WAIT, SHALL sample mem_resp_valid only there; a response in the handshake cycle SHALL be ignored.
REQ-023 In WAIT, a response SHALL capture mem_resp_data and mem_resp_err and move to WB.
REQ-024 The WAIT counter SHALL reach TIMEOUT with no response, then force an error to WB.
REQ-025 Load data SHALL be mem_resp_data shifted right by 8*addr[1:0], then truncated to byte or half.
REQ-026 Truncated load data SHALL be sign-extended if rsign, else zero-extended; word loads SHALL be unmodified.
REQ-027 In WB, for exactly one cycle, SHALL assert abt_finish=1 with abt_frd=latched ard, and commit_pc=latched pc.
REQ-028 In WB, gpr_wen SHALL equal (abt_gen or a successful load) and no error and ard!=0.
REQ-029 gpr_wdata SHALL be the load data for loads, else the latched abt_rd.
REQ-030 In WB, csr_wen SHALL equal the latched abt_sen, with csr_waddr and csr_wdata taken from the latched acsr and csr, including on LSU error.
REQ-031 A bus error or timeout SHALL raise lsu_err with errtp 5 (load) or 7 (store) and suppress gpr_wen.
REQ-032 WB SHALL return to IDLE on the next edge, so back-to-back requests retire no faster than every 2 cycles.
REQ-033 Latency SHALL be:
- non-memory: accept at T, finish at T+1;
- memory, zero-wait: accept T, handshake T+1, response T+2, finish T+3.
REQ-034 Stores SHALL wait for a response before finishing.
REQ-035 gpr_wen, csr_wen, abt_finish and lsu_err SHALL be 0 in all states except WB.

Reset
REQ-036 While reset=0, SHALL force state=IDLE, counter=0, and all outputs to 0, including abt_ready and mem_req_valid.
REQ-037 Reset asserted mid-REQ or mid-WAIT SHALL abort the transaction: no finish or writeback, and a later response is ignored in IDLE.
REQ-038 After reset deasserts, abt_ready SHALL be 1 at the first edge.

Verification
REQ-039 Verification SHALL cover a non-memory request: gen=1, ard=5, rd=0x1234 -> finish at T+1, gpr_wen=1, waddr=5, wdata=0x1234, no mem_req_valid.
REQ-040 Verification SHALL cover a signed byte load: addr=0x80000003, resp_data=0x80FF0000 -> gpr_wdata=0xFFFFFF80; same with rsign=0 -> 0x00000080.
REQ-041 Verification SHALL cover a half store: addr=0x80000002, wdata=0xABCD -> wstrb=1100, mem_req_wdata=0xABCDABCD, gpr_wen=0, finish after response.
REQ-042 Verification SHALL cover a word load at addr=0x80000001 -> no mem_req_valid, lsu_err=1, errtp=4, gpr_wen=0, finish at T+1.
REQ-043 Verification SHALL cover mem_req_ready held low 10 cycles, then a response with err=1 on a load -> request stable 10 cycles, errtp=5, gpr_wen=0.
REQ-044 Verification SHALL cover TIMEOUT=4 with no response -> errtp=7 (store) after 4 WAIT cycles; reset pulsed in WAIT -> no finish, abt_ready=1 after release.
